// File: rtl/cpu_ctrl.sv
// Microsequencer for the 8-bit accumulator CPU: decodes state, opcode and zero into datapath
// strobes and keeps the single-driver discipline on the shared bus.
module cpu_ctrl #(
  parameter int unsigned RET_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             pc_oe,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             mar_ld,
  output logic             mem_oe,
  output logic             mem_we,
  output logic             ir_ld,
  output logic             ir_oe,
  output logic             acc_oe,
  output logic             acc_ld,
  output logic             b_ld,
  output logic             alu_oe,
  output logic             alu_sub,
  output logic             halt,
  output logic [RET_W-1:0] retired
);

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpLda = 3'b001;
  localparam logic [2:0] OpSta = 3'b010;
  localparam logic [2:0] OpAdd = 3'b011;
  localparam logic [2:0] OpSub = 3'b100;
  localparam logic [2:0] OpJmp = 3'b101;
  localparam logic [2:0] OpJz  = 3'b110;
  localparam logic [2:0] OpHlt = 3'b111;

  typedef enum logic [2:0] {
    StFetchA,
    StFetchB,
    StExec1,
    StExec2,
    StExec3,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetchA;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Everything is gated by rst_n so a reset mid-instruction issues no partial strobe.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    pc_oe   = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    mar_ld  = 1'b0;
    mem_oe  = 1'b0;
    mem_we  = 1'b0;
    ir_ld   = 1'b0;
    ir_oe   = 1'b0;
    acc_oe  = 1'b0;
    acc_ld  = 1'b0;
    b_ld    = 1'b0;
    alu_oe  = 1'b0;
    alu_sub = 1'b0;
    halt    = 1'b0;

    if (rst_n) begin
      if (state_q == StHalt) begin
        halt = 1'b1;
      end else if (en) begin
        case (state_q)
          StFetchA: begin
            pc_oe   = 1'b1;
            mar_ld  = 1'b1;
            state_d = StFetchB;
          end
          StFetchB: begin
            mem_oe  = 1'b1;
            ir_ld   = 1'b1;
            pc_inc  = 1'b1;
            state_d = StExec1;
          end
          StExec1: begin
            case (opcode)
              OpLda, OpSta, OpAdd, OpSub: begin
                ir_oe   = 1'b1;
                mar_ld  = 1'b1;
                state_d = StExec2;
              end
              OpJmp: begin
                ir_oe   = 1'b1;
                pc_ld   = 1'b1;
                retire  = 1'b1;
                state_d = StFetchA;
              end
              OpJz: begin
                ir_oe   = zero;
                pc_ld   = zero;
                retire  = 1'b1;
                state_d = StFetchA;
              end
              OpHlt: begin
                retire  = 1'b1;
                state_d = StHalt;
              end
              default: begin
                retire  = 1'b1;
                state_d = StFetchA;
              end
            endcase
          end
          StExec2: begin
            case (opcode)
              OpLda: begin
                mem_oe  = 1'b1;
                acc_ld  = 1'b1;
                retire  = 1'b1;
                state_d = StFetchA;
              end
              OpSta: begin
                acc_oe  = 1'b1;
                mem_we  = 1'b1;
                retire  = 1'b1;
                state_d = StFetchA;
              end
              OpAdd, OpSub: begin
                mem_oe  = 1'b1;
                b_ld    = 1'b1;
                state_d = StExec3;
              end
              default: begin
                retire  = 1'b1;
                state_d = StFetchA;
              end
            endcase
          end
          StExec3: begin
            alu_oe  = 1'b1;
            acc_ld  = 1'b1;
            alu_sub = (opcode == OpSub);
            retire  = 1'b1;
            state_d = StFetchA;
          end
          default: state_d = StFetchA;
        endcase
      end
    end

    retired_d = retire ? retired_q + RET_W'(1) : retired_q;
  end

  // OpNop is handled by the default arm of the EXEC1 decode.
  logic unused_op;
  assign unused_op = (opcode == OpNop);

  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: a small datapath executes the strobes, and an instruction-level model
// predicts registers, memory, retired count and cycle counts.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [2:0]  opcode;
  logic        zero;
  logic        pc_oe, pc_inc, pc_ld, mar_ld, mem_oe, mem_we, ir_ld, ir_oe;
  logic        acc_oe, acc_ld, b_ld, alu_oe, alu_sub, halt;
  logic [15:0] retired;

  always #5 clk = ~clk;

  cpu_ctrl #(.RET_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .opcode  (opcode),
    .zero    (zero),
    .pc_oe   (pc_oe),
    .pc_inc  (pc_inc),
    .pc_ld   (pc_ld),
    .mar_ld  (mar_ld),
    .mem_oe  (mem_oe),
    .mem_we  (mem_we),
    .ir_ld   (ir_ld),
    .ir_oe   (ir_oe),
    .acc_oe  (acc_oe),
    .acc_ld  (acc_ld),
    .b_ld    (b_ld),
    .alu_oe  (alu_oe),
    .alu_sub (alu_sub),
    .halt    (halt),
    .retired (retired)
  );

  // Datapath driven purely by the controller's strobes.
  logic [7:0] prog [32];
  logic [7:0] ram  [32];
  logic [4:0] pc, mar;
  logic [7:0] ir, acc, b, bus, acc_init;
  logic       load;

  always_comb begin
    bus = 8'h00;
    if (pc_oe)  bus = bus | {3'b000, pc};
    if (mem_oe) bus = bus | ram[mar];
    if (ir_oe)  bus = bus | {3'b000, ir[4:0]};
    if (acc_oe) bus = bus | acc;
    if (alu_oe) bus = bus | (alu_sub ? acc - b : acc + b);
  end

  assign opcode = ir[7:5];
  assign zero   = (acc == 8'h00);

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) ram[i] <= prog[i];
      pc  <= 5'd0;
      mar <= 5'd0;
      ir  <= 8'h00;
      b   <= 8'h00;
      acc <= acc_init;
    end else begin
      if (pc_inc) pc <= pc + 5'd1;
      if (pc_ld)  pc <= bus[4:0];
      if (mar_ld) mar <= bus[4:0];
      if (mem_we) ram[mar] <= bus;
      if (ir_ld)  ir <= bus;
      if (acc_ld) acc <= bus;
      if (b_ld)   b <= bus;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] strobes();
    return {pc_oe, pc_inc, pc_ld, mar_ld, mem_oe, mem_we, ir_ld, ir_oe,
            acc_oe, acc_ld, b_ld, alu_oe, alu_sub, halt};
  endfunction

  task automatic check_inv();
    logic [13:0] s;
    int n;
    s = strobes();
    n = int'(pc_oe) + int'(mem_oe) + int'(ir_oe) + int'(acc_oe) + int'(alu_oe);
    chk("one_bus_driver", 32'(n <= 1), 32'd1);
    chk("pc_inc_and_ld", 32'(pc_inc & pc_ld), 32'd0);
    chk("alu_sub_outside_exec3", 32'(alu_sub & ~(alu_oe & acc_ld)), 32'd0);
    chk("halt_with_strobes", 32'(halt && (s[13:1] != 13'd0)), 32'd0);
    if (!rst_n) chk("strobes_in_reset", 32'(s), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_inv();
  endtask

  // Reset controller and load the datapath; returns at cycle 0 (first FETCH_A).
  task automatic start();
    en    = 1'b1;
    load  = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_strobes", 32'(strobes()), 32'd0);
    load  = 1'b0;
    rst_n = 1'b1;
    #1;
    check_inv();
    chk("cycle0_pc_oe", 32'(pc_oe & mar_ld), 32'd1);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    acc_init = 8'h00;
  endtask

  // Instruction-level reference.
  logic [7:0] m_mem [32];
  logic [7:0] m_acc;
  logic [4:0] m_pc;
  int         m_ret, m_cyc;
  bit         m_halted;

  task automatic model_run(input int max_instr);
    logic [7:0] ins;
    logic [4:0] a;
    for (int i = 0; i < 32; i++) m_mem[i] = prog[i];
    m_acc = acc_init;
    m_pc = 5'd0;
    m_ret = 0;
    m_cyc = 0;
    m_halted = 1'b0;
    while (m_ret < max_instr && !m_halted) begin
      ins  = m_mem[m_pc];
      a    = ins[4:0];
      m_pc = m_pc + 5'd1;
      case (ins[7:5])
        3'd0: m_cyc += 3;
        3'd1: begin m_acc = m_mem[a]; m_cyc += 4; end
        3'd2: begin m_mem[a] = m_acc; m_cyc += 4; end
        3'd3: begin m_acc = m_acc + m_mem[a]; m_cyc += 5; end
        3'd4: begin m_acc = m_acc - m_mem[a]; m_cyc += 5; end
        3'd5: begin m_pc = a; m_cyc += 3; end
        3'd6: begin if (m_acc == 8'h00) m_pc = a; m_cyc += 3; end
        default: begin m_halted = 1'b1; m_cyc += 3; end
      endcase
      m_ret++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    load = 1'b0;

    // LDA 10; ADD 11; STA 12; HLT
    clear_prog();
    prog[0] = 8'h2A; prog[1] = 8'h6B; prog[2] = 8'h4C; prog[3] = 8'hE0;
    prog[10] = 8'h05; prog[11] = 8'h07;
    start();
    repeat (15) tick();
    chk("halt_before_16", 32'(halt), 32'd0);
    tick();
    chk("halt_at_16", 32'(halt), 32'd1);
    chk("add_ram12", 32'(ram[12]), 32'h0C);
    chk("add_retired", 32'(retired), 32'd4);
    en = 1'b0;
    tick();
    chk("halt_ignores_en", 32'(halt), 32'd1);
    chk("halt_retired_hold", 32'(retired), 32'd4);

    // SUB wrap: LDA 10; SUB 11; STA 12; HLT
    clear_prog();
    prog[0] = 8'h2A; prog[1] = 8'h8B; prog[2] = 8'h4C; prog[3] = 8'hE0;
    prog[10] = 8'h03; prog[11] = 8'h05;
    start();
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("alu_sub_cycle%0d", k), 32'(alu_sub), 32'(k == 8));
      if (k < 16) tick();
    end
    chk("sub_acc", 32'(acc), 32'hFE);
    chk("sub_ram12", 32'(ram[12]), 32'hFE);

    // JZ taken / not taken
    for (int z = 0; z < 2; z++) begin
      clear_prog();
      prog[0] = 8'hC7; prog[7] = 8'hE0;
      acc_init = 8'(z);
      start();
      tick();
      tick();
      chk($sformatf("jz%0d_pc_ld", z), 32'(pc_ld), 32'(z == 0));
      tick();
      chk($sformatf("jz%0d_fetch", z), 32'(pc_oe), 32'd1);
      chk($sformatf("jz%0d_pc", z), 32'(pc), (z == 0) ? 32'd7 : 32'd1);
      chk($sformatf("jz%0d_retired", z), 32'(retired), 32'd1);
    end

    // en low for 4 cycles from EXEC1 of ADD
    clear_prog();
    prog[0] = 8'h2A; prog[1] = 8'h6B; prog[2] = 8'h4C; prog[3] = 8'hE0;
    prog[10] = 8'h05; prog[11] = 8'h07;
    start();
    repeat (6) tick();
    chk("stall_pre_e1", 32'(ir_oe & mar_ld), 32'd1);
    en = 1'b0;
    #1;
    chk("stall_strobes_c6", 32'(strobes()), 32'd0);
    for (int k = 7; k <= 10; k++) begin
      tick();
      chk($sformatf("stall_strobes_c%0d", k), 32'(strobes()), 32'd0);
      chk($sformatf("stall_retired_c%0d", k), 32'(retired), 32'd1);
    end
    en = 1'b1;
    #1;
    chk("stall_resume_e1", 32'(ir_oe & mar_ld), 32'd1);
    tick();
    chk("stall_e2", 32'(mem_oe & b_ld), 32'd1);
    tick();
    chk("stall_e3", 32'(alu_oe & acc_ld), 32'd1);
    chk("stall_retired_c12", 32'(retired), 32'd1);
    tick();
    chk("stall_retired_c13", 32'(retired), 32'd2);
    chk("stall_next_fetch", 32'(pc_oe), 32'd1);
    repeat (6) tick();
    chk("stall_halt_c19", 32'(halt), 32'd0);
    tick();
    chk("stall_halt_c20", 32'(halt), 32'd1);
    chk("stall_ram12", 32'(ram[12]), 32'h0C);

    // Reset pulse during EXEC2 of STA
    clear_prog();
    prog[0] = 8'h2A; prog[1] = 8'h4C; prog[2] = 8'hE0;
    prog[10] = 8'h55; prog[12] = 8'h99;
    start();
    repeat (6) tick();
    chk("rst_pre_retired", 32'(retired), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_no_mem_we", 32'(mem_we), 32'd0);
    check_inv();
    tick();
    chk("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_fetch_a", 32'(pc_oe & mar_ld), 32'd1);
    chk("rst_ram12_kept", 32'(ram[12]), 32'h99);
    chk("rst_retired_after", 32'(retired), 32'd0);

    // Random programs against the instruction-level model
    for (int it = 0; it < 24; it++) begin
      int maxi;
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      acc_init = 8'($urandom);
      maxi = int'($urandom_range(4, 30));
      model_run(maxi);
      start();
      repeat (m_cyc) tick();
      chk($sformatf("rnd%0d_pc", it), 32'(pc), 32'(m_pc));
      chk($sformatf("rnd%0d_acc", it), 32'(acc), 32'(m_acc));
      chk($sformatf("rnd%0d_retired", it), 32'(retired), 32'(m_ret));
      chk($sformatf("rnd%0d_halt", it), 32'(halt), 32'(m_halted));
      chk($sformatf("rnd%0d_fetch", it), 32'(pc_oe), 32'(!m_halted));
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("rnd%0d_ram%0d", it, i), 32'(ram[i]), 32'(m_mem[i]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
